// File: rtl/rv32imc_types.sv
// rv32imc_types: shared pipeline register layouts, memory op encodings and memory-stage FSM states
package rv32imc_types;

    typedef enum logic [1:0] {MS_IDLE, MS_WAIT, MS_HOLD} mem_state_e;

    // op[1:0] is the access size (byte/half/word), op[2] unsigned load, op[3] store
    typedef enum logic [3:0] {
        MEM_LB  = 4'h0,
        MEM_LH  = 4'h1,
        MEM_LW  = 4'h2,
        MEM_LBU = 4'h4,
        MEM_LHU = 4'h5,
        MEM_SB  = 4'h8,
        MEM_SH  = 4'h9,
        MEM_SW  = 4'ha
    } mem_op_e;

    typedef struct packed {
        logic    mem_read;
        logic    mem_write;
        mem_op_e mem_op;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regf_we;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } ex_stage_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] mem_rdata;
        logic [4:0]  rd_addr;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } mem_stage_t;

    function automatic logic [3:0] byte_mask(logic [1:0] size, logic [1:0] a);
        return size[1] ? 4'b1111 : size[0] ? 4'b0011 << {a[1], 1'b0} : 4'b0001 << a;
    endfunction

    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] a);
        return size[1] ? |a : size[0] & a[0];
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: shifts the addressed lanes of a load word down and sign/zero-extends by size
module load_align
    import rv32imc_types::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] r;

    assign r = rdata >> {addr, 3'b000};

    always_comb begin
        data = op[3] ? 32'h0
             : op[1] ? r
             : op[0] ? {{16{r[15] & ~op[2]}}, r[15:0]}
             : {{24{r[7] & ~op[2]}}, r[7:0]};
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: issues one data-memory access per EX/MEM instruction and builds the MEM/WB register
module mem_stage
    import rv32imc_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_reg_we,
    input  ex_stage_t   ex_stage_reg,
    output mem_stage_t  mem_stage_reg,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        o_dmem_stall,
    output logic        o_misaligned
);

    mem_state_e  state;
    mem_stage_t  nxt;
    logic        issued, is_mem, access, issue, latch, rd_acc, wr_acc;
    logic [31:0] buffer, rdata_src, load_data;
    logic [3:0]  mask;

    assign is_mem       = ex_stage_reg.mem_ctrl.mem_read | ex_stage_reg.mem_ctrl.mem_write;
    assign o_misaligned = is_mem & is_misaligned(ex_stage_reg.mem_ctrl.mem_op[1:0], ex_stage_reg.alu_out[1:0]);
    assign access       = is_mem & ~o_misaligned;
    assign rd_acc       = access & ex_stage_reg.mem_ctrl.mem_read;
    assign wr_acc       = access & ex_stage_reg.mem_ctrl.mem_write;
    assign issue        = ~rst & access & ~issued & state == MS_IDLE;
    assign o_dmem_stall = issue | (~rst & state == MS_WAIT & ~dmem_resp);
    assign latch        = mem_reg_we & ~o_dmem_stall;
    assign mask         = byte_mask(ex_stage_reg.mem_ctrl.mem_op[1:0], ex_stage_reg.alu_out[1:0]);
    assign dmem_addr    = {ex_stage_reg.alu_out[31:2], 2'b00};
    assign dmem_wdata   = ex_stage_reg.rs2_rdata << {ex_stage_reg.alu_out[1:0], 3'b000};
    assign dmem_rmask   = issue & ex_stage_reg.mem_ctrl.mem_read ? mask : 4'b0000;
    assign dmem_wmask   = issue & ex_stage_reg.mem_ctrl.mem_write ? mask : 4'b0000;
    // a response captured while the pipeline was frozen is replayed from the buffer
    assign rdata_src    = state == MS_HOLD ? buffer : dmem_rdata;

    load_align u_load_align (
        .op    (ex_stage_reg.mem_ctrl.mem_op),
        .addr  (ex_stage_reg.alu_out[1:0]),
        .rdata (rdata_src),
        .data  (load_data)
    );

    always_comb begin
        nxt                 = '0;
        nxt.alu_out         = ex_stage_reg.alu_out;
        nxt.rd_addr         = ex_stage_reg.rd_addr;
        nxt.wb_ctrl         = ex_stage_reg.wb_ctrl;
        nxt.wb_ctrl.regf_we = ex_stage_reg.wb_ctrl.regf_we & ~o_misaligned;
        nxt.mem_rdata       = rd_acc ? load_data : 32'h0;
        nxt.rvfi            = ex_stage_reg.rvfi;
        nxt.rvfi.mem_addr   = access ? dmem_addr : 32'h0;
        nxt.rvfi.mem_rmask  = rd_acc ? mask : 4'b0000;
        nxt.rvfi.mem_wmask  = wr_acc ? mask : 4'b0000;
        nxt.rvfi.mem_rdata  = rd_acc ? rdata_src : 32'h0;
        nxt.rvfi.mem_wdata  = wr_acc ? dmem_wdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= MS_IDLE;
            issued        <= 1'b0;
            buffer        <= 32'h0;
            mem_stage_reg <= '0;
        end else begin
            issued <= issue ? 1'b1 : latch ? 1'b0 : issued;
            state  <= issue ? MS_WAIT
                    : state == MS_WAIT && dmem_resp ? (mem_reg_we ? MS_IDLE : MS_HOLD)
                    : state == MS_HOLD && mem_reg_we ? MS_IDLE
                    : state;
            if (state == MS_WAIT && dmem_resp && !mem_reg_we)
                buffer <= dmem_rdata;
            if (latch)
                mem_stage_reg <= nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenario tests for mem_stage with hand-computed expectations
module tb_mem_stage;
    import rv32imc_types::*;

    logic        clk = 1'b0;
    logic        rst, mem_reg_we, dmem_resp, o_dmem_stall, o_misaligned;
    ex_stage_t   ex_stage_reg;
    mem_stage_t  mem_stage_reg;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    int          total = 0;
    int          bad = 0;

    logic [3:0]  rm, wm;
    logic [31:0] a, wd;
    int          stalls, reissues;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .mem_reg_we    (mem_reg_we),
        .ex_stage_reg  (ex_stage_reg),
        .mem_stage_reg (mem_stage_reg),
        .dmem_addr     (dmem_addr),
        .dmem_rmask    (dmem_rmask),
        .dmem_wmask    (dmem_wmask),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_resp     (dmem_resp),
        .o_dmem_stall  (o_dmem_stall),
        .o_misaligned  (o_misaligned)
    );

    function automatic ex_stage_t mk(mem_op_e op, logic rd_en, logic wr_en, logic [31:0] addr,
                                     logic [31:0] rs2, logic [4:0] rd, logic we);
        ex_stage_t e;
        e = '0;
        e.alu_out            = addr;
        e.rs2_rdata          = rs2;
        e.rd_addr            = rd;
        e.mem_ctrl.mem_read  = rd_en;
        e.mem_ctrl.mem_write = wr_en;
        e.mem_ctrl.mem_op    = op;
        e.wb_ctrl.regf_we    = we;
        e.rvfi.valid         = 1'b1;
        e.rvfi.pc            = addr ^ 32'h8000_0000;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // issue cycle, 'waits' WAIT cycles, response cycle; then the EX/MEM slot becomes a bubble
    task automatic run_access(input ex_stage_t e, input int waits, input logic [31:0] rd);
        ex_stage_reg = e;
        #1;
        rm = dmem_rmask; wm = dmem_wmask; a = dmem_addr; wd = dmem_wdata;
        stalls = int'(o_dmem_stall);
        reissues = 0;
        tick;
        for (int i = 0; i < waits; i++) begin
            stalls += int'(o_dmem_stall);
            if ((dmem_rmask | dmem_wmask) != 4'b0000) reissues++;
            tick;
        end
        dmem_resp = 1'b1; dmem_rdata = rd;
        #1;
        stalls += int'(o_dmem_stall);
        if ((dmem_rmask | dmem_wmask) != 4'b0000) reissues++;
        tick;
        dmem_resp = 1'b0; dmem_rdata = 32'h0; ex_stage_reg = '0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_reg_we = 1'b1; dmem_resp = 1'b0; dmem_rdata = 32'h0;
        ex_stage_reg = mk(MEM_LW, 1'b1, 1'b0, 32'h100, 32'h0, 5'd1, 1'b1);
        #1;
        total++; if (dmem_rmask !== 4'b0000) begin bad++; $display("FAIL rst_rmask got=%b want=0000", dmem_rmask); end
        total++; if (dmem_wmask !== 4'b0000) begin bad++; $display("FAIL rst_wmask got=%b want=0000", dmem_wmask); end
        total++; if (o_dmem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", o_dmem_stall); end
        tick;
        tick;
        total++; if (mem_stage_reg !== mem_stage_t'('0)) begin bad++; $display("FAIL rst_memwb got=%h want=0", mem_stage_reg); end
        rst = 1'b0; ex_stage_reg = '0;
        tick;
    endtask

    task automatic test_lw;
        run_access(mk(MEM_LW, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1), 3, 32'hDEAD_BEEF);
        total++; if (rm !== 4'b1111) begin bad++; $display("FAIL lw_rmask got=%b want=1111", rm); end
        total++; if (wm !== 4'b0000) begin bad++; $display("FAIL lw_wmask got=%b want=0000", wm); end
        total++; if (a !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h want=00000100", a); end
        total++; if (stalls !== 4) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=4", stalls); end
        total++; if (reissues !== 0) begin bad++; $display("FAIL lw_reissue got=%0d want=0", reissues); end
        total++; if (mem_stage_reg.mem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rdata got=%h want=deadbeef", mem_stage_reg.mem_rdata); end
        total++; if (mem_stage_reg.rd_addr !== 5'd3) begin bad++; $display("FAIL lw_rd got=%0d want=3", mem_stage_reg.rd_addr); end
        total++; if (mem_stage_reg.wb_ctrl.regf_we !== 1'b1) begin bad++; $display("FAIL lw_regf_we got=%b want=1", mem_stage_reg.wb_ctrl.regf_we); end
        total++; if (mem_stage_reg.rvfi.mem_rmask !== 4'b1111) begin bad++; $display("FAIL lw_rvfi_rmask got=%b want=1111", mem_stage_reg.rvfi.mem_rmask); end
        total++; if (mem_stage_reg.rvfi.mem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rvfi_rdata got=%h want=deadbeef", mem_stage_reg.rvfi.mem_rdata); end
        total++; if (dmem_rmask !== 4'b0000 || o_dmem_stall !== 1'b0) begin bad++; $display("FAIL lw_after got=%b/%b want=0000/0", dmem_rmask, o_dmem_stall); end
    endtask

    task automatic test_lb;
        run_access(mk(MEM_LB, 1'b1, 1'b0, 32'h103, 32'h0, 5'd4, 1'b1), 1, 32'h80FF_FF00);
        total++; if (rm !== 4'b1000) begin bad++; $display("FAIL lb_rmask got=%b want=1000", rm); end
        total++; if (a !== 32'h100) begin bad++; $display("FAIL lb_addr got=%h want=00000100", a); end
        total++; if (stalls !== 2) begin bad++; $display("FAIL lb_stall_cycles got=%0d want=2", stalls); end
        total++; if (mem_stage_reg.mem_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h want=ffffff80", mem_stage_reg.mem_rdata); end
        total++; if (mem_stage_reg.rvfi.mem_rdata !== 32'h80FF_FF00) begin bad++; $display("FAIL lb_rvfi_raw got=%h want=80ffff00", mem_stage_reg.rvfi.mem_rdata); end
        run_access(mk(MEM_LBU, 1'b1, 1'b0, 32'h103, 32'h0, 5'd4, 1'b1), 1, 32'h80FF_FF00);
        total++; if (rm !== 4'b1000) begin bad++; $display("FAIL lbu_rmask got=%b want=1000", rm); end
        total++; if (mem_stage_reg.mem_rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_rdata got=%h want=00000080", mem_stage_reg.mem_rdata); end
    endtask

    task automatic test_sh;
        run_access(mk(MEM_SH, 1'b0, 1'b1, 32'h202, 32'h0000_1234, 5'd0, 1'b0), 0, 32'hFFFF_FFFF);
        total++; if (wm !== 4'b1100) begin bad++; $display("FAIL sh_wmask got=%b want=1100", wm); end
        total++; if (rm !== 4'b0000) begin bad++; $display("FAIL sh_rmask got=%b want=0000", rm); end
        total++; if (wd !== 32'h1234_0000) begin bad++; $display("FAIL sh_wdata got=%h want=12340000", wd); end
        total++; if (a !== 32'h200) begin bad++; $display("FAIL sh_addr got=%h want=00000200", a); end
        total++; if (stalls !== 1) begin bad++; $display("FAIL sh_stall_cycles got=%0d want=1", stalls); end
        total++; if (mem_stage_reg.mem_rdata !== 32'h0) begin bad++; $display("FAIL sh_memrdata got=%h want=0", mem_stage_reg.mem_rdata); end
        total++; if (mem_stage_reg.rvfi.mem_wmask !== 4'b1100) begin bad++; $display("FAIL sh_rvfi_wmask got=%b want=1100", mem_stage_reg.rvfi.mem_wmask); end
        total++; if (mem_stage_reg.rvfi.mem_wdata !== 32'h1234_0000) begin bad++; $display("FAIL sh_rvfi_wdata got=%h want=12340000", mem_stage_reg.rvfi.mem_wdata); end
    endtask

    task automatic test_back_to_back;
        run_access(mk(MEM_SB, 1'b0, 1'b1, 32'h201, 32'h0000_00AB, 5'd0, 1'b0), 0, 32'h0);
        total++; if (wm !== 4'b0010) begin bad++; $display("FAIL sb_wmask got=%b want=0010", wm); end
        total++; if (wd !== 32'h0000_AB00) begin bad++; $display("FAIL sb_wdata got=%h want=0000ab00", wd); end
        run_access(mk(MEM_LH, 1'b1, 1'b0, 32'h506, 32'h0, 5'd8, 1'b1), 0, 32'h8001_0000);
        total++; if (rm !== 4'b1100) begin bad++; $display("FAIL lh_rmask got=%b want=1100", rm); end
        total++; if (a !== 32'h504) begin bad++; $display("FAIL lh_addr got=%h want=00000504", a); end
        total++; if (mem_stage_reg.mem_rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_rdata got=%h want=ffff8001", mem_stage_reg.mem_rdata); end
        run_access(mk(MEM_LHU, 1'b1, 1'b0, 32'h506, 32'h0, 5'd8, 1'b1), 0, 32'h8001_0000);
        total++; if (rm !== 4'b1100) begin bad++; $display("FAIL lhu_rmask got=%b want=1100", rm); end
        total++; if (mem_stage_reg.mem_rdata !== 32'h0000_8001) begin bad++; $display("FAIL lhu_rdata got=%h want=00008001", mem_stage_reg.mem_rdata); end
    endtask

    task automatic test_misaligned;
        ex_stage_reg = mk(MEM_LW, 1'b1, 1'b0, 32'h101, 32'h0, 5'd9, 1'b1);
        #1;
        total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL mis_lw_flag got=%b want=1", o_misaligned); end
        total++; if ((dmem_rmask | dmem_wmask) !== 4'b0000) begin bad++; $display("FAIL mis_lw_masks got=%b/%b want=0000", dmem_rmask, dmem_wmask); end
        total++; if (o_dmem_stall !== 1'b0) begin bad++; $display("FAIL mis_lw_stall got=%b want=0", o_dmem_stall); end
        tick;
        total++; if (mem_stage_reg.wb_ctrl.regf_we !== 1'b0) begin bad++; $display("FAIL mis_lw_regf_we got=%b want=0", mem_stage_reg.wb_ctrl.regf_we); end
        total++; if (mem_stage_reg.alu_out !== 32'h101 || mem_stage_reg.rd_addr !== 5'd9) begin bad++; $display("FAIL mis_lw_pass got=%h/%0d want=00000101/9", mem_stage_reg.alu_out, mem_stage_reg.rd_addr); end
        ex_stage_reg = mk(MEM_SH, 1'b0, 1'b1, 32'h203, 32'h0, 5'd0, 1'b0);
        #1;
        total++; if (o_misaligned !== 1'b1 || dmem_wmask !== 4'b0000) begin bad++; $display("FAIL mis_sh got=%b/%b want=1/0000", o_misaligned, dmem_wmask); end
        ex_stage_reg = mk(MEM_SB, 1'b0, 1'b1, 32'h203, 32'h0, 5'd0, 1'b0);
        #1;
        total++; if (o_misaligned !== 1'b0 || dmem_wmask !== 4'b1000) begin bad++; $display("FAIL sb_edge got=%b/%b want=0/1000", o_misaligned, dmem_wmask); end
        ex_stage_reg = '0;
        #1;
        tick;
    endtask

    task automatic test_hold;
        ex_stage_reg = mk(MEM_LW, 1'b1, 1'b0, 32'h300, 32'h0, 5'd5, 1'b1);
        mem_reg_we = 1'b1;
        #1;
        total++; if (dmem_rmask !== 4'b1111) begin bad++; $display("FAIL hold_issue got=%b want=1111", dmem_rmask); end
        tick;
        mem_reg_we = 1'b0;
        #1;
        total++; if (o_dmem_stall !== 1'b1) begin bad++; $display("FAIL hold_wait_stall got=%b want=1", o_dmem_stall); end
        tick;
        dmem_resp = 1'b1; dmem_rdata = 32'h1122_3344;
        #1;
        total++; if (o_dmem_stall !== 1'b0) begin bad++; $display("FAIL hold_resp_stall got=%b want=0", o_dmem_stall); end
        tick;
        dmem_resp = 1'b0; dmem_rdata = 32'hBADB_AD00;
        #1;
        total++; if (o_dmem_stall !== 1'b0 || dmem_rmask !== 4'b0000) begin bad++; $display("FAIL hold1 got=%b/%b want=0/0000", o_dmem_stall, dmem_rmask); end
        total++; if (mem_stage_reg.rd_addr !== 5'd0) begin bad++; $display("FAIL hold1_nolatch got=%0d want=0", mem_stage_reg.rd_addr); end
        tick;
        dmem_resp = 1'b1; dmem_rdata = 32'h5555_5555;
        #1;
        total++; if (o_dmem_stall !== 1'b0 || dmem_rmask !== 4'b0000) begin bad++; $display("FAIL hold2 got=%b/%b want=0/0000", o_dmem_stall, dmem_rmask); end
        tick;
        dmem_resp = 1'b0; mem_reg_we = 1'b1;
        #1;
        total++; if (o_dmem_stall !== 1'b0 || dmem_rmask !== 4'b0000) begin bad++; $display("FAIL hold_release got=%b/%b want=0/0000", o_dmem_stall, dmem_rmask); end
        tick;
        ex_stage_reg = '0; dmem_rdata = 32'h0;
        #1;
        total++; if (mem_stage_reg.mem_rdata !== 32'h1122_3344) begin bad++; $display("FAIL hold_rdata got=%h want=11223344", mem_stage_reg.mem_rdata); end
        total++; if (mem_stage_reg.rd_addr !== 5'd5) begin bad++; $display("FAIL hold_rd got=%0d want=5", mem_stage_reg.rd_addr); end
        tick;
    endtask

    task automatic test_nonmem;
        ex_stage_reg = mk(MEM_LB, 1'b0, 1'b0, 32'h0000_CAFE, 32'h0, 5'd7, 1'b1);
        dmem_resp = 1'b1; dmem_rdata = 32'h9999_9999;
        #1;
        total++; if (o_dmem_stall !== 1'b0 || (dmem_rmask | dmem_wmask) !== 4'b0000) begin bad++; $display("FAIL alu_idle got=%b/%b/%b want=0/0000/0000", o_dmem_stall, dmem_rmask, dmem_wmask); end
        tick;
        dmem_resp = 1'b0; dmem_rdata = 32'h0; ex_stage_reg = '0;
        total++; if (mem_stage_reg.alu_out !== 32'h0000_CAFE) begin bad++; $display("FAIL alu_pass got=%h want=0000cafe", mem_stage_reg.alu_out); end
        total++; if (mem_stage_reg.mem_rdata !== 32'h0) begin bad++; $display("FAIL alu_rdata got=%h want=0", mem_stage_reg.mem_rdata); end
        total++; if (mem_stage_reg.wb_ctrl.regf_we !== 1'b1) begin bad++; $display("FAIL alu_regf_we got=%b want=1", mem_stage_reg.wb_ctrl.regf_we); end
        tick;
    endtask

    task automatic test_reset_wait;
        ex_stage_reg = mk(MEM_LW, 1'b1, 1'b0, 32'h400, 32'h0, 5'd6, 1'b1);
        #1;
        tick;
        total++; if (o_dmem_stall !== 1'b1) begin bad++; $display("FAIL rw_wait_stall got=%b want=1", o_dmem_stall); end
        rst = 1'b1; ex_stage_reg = '0;
        #1;
        total++; if (o_dmem_stall !== 1'b0 || dmem_rmask !== 4'b0000) begin bad++; $display("FAIL rw_rst_cycle got=%b/%b want=0/0000", o_dmem_stall, dmem_rmask); end
        tick;
        rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
        #1;
        total++; if (o_dmem_stall !== 1'b0 || (dmem_rmask | dmem_wmask) !== 4'b0000) begin bad++; $display("FAIL rw_late_resp got=%b/%b/%b want=0/0000/0000", o_dmem_stall, dmem_rmask, dmem_wmask); end
        total++; if (mem_stage_reg !== mem_stage_t'('0)) begin bad++; $display("FAIL rw_memwb_zero got=%h want=0", mem_stage_reg); end
        tick;
        dmem_resp = 1'b0; dmem_rdata = 32'h0;
        total++; if (mem_stage_reg !== mem_stage_t'('0)) begin bad++; $display("FAIL rw_resp_ignored got=%h want=0", mem_stage_reg); end
        run_access(mk(MEM_LW, 1'b1, 1'b0, 32'h404, 32'h0, 5'd2, 1'b1), 0, 32'h1234_5678);
        total++; if (rm !== 4'b1111 || stalls !== 1) begin bad++; $display("FAIL rw_next_issue got=%b/%0d want=1111/1", rm, stalls); end
        total++; if (mem_stage_reg.mem_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rw_next_rdata got=%h want=12345678", mem_stage_reg.mem_rdata); end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_lb;
        test_sh;
        test_back_to_back;
        test_misaligned;
        test_hold;
        test_nonmem;
        test_reset_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
